// File: rtl/relu_requant_stage.sv
// Requantizes the multiplier's signed 16-bit results to signed 8-bit with optional ReLU,
// frames them into vectors and buffers them in a small output FIFO.
module relu_requant_stage #(
  parameter int VEC_LEN    = 3,
  parameter int SHIFT      = 0,
  parameter int RELU_EN    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] data_in,
  input  logic        ovf_in,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  data_out,
  output logic        m_last,
  output logic        vec_overflow
);

  localparam int EW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       vov;
  } entry_t;

  entry_t mem [FIFO_DEPTH];

  logic [EW-1:0] elem;
  logic          sticky;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    hold_data;

  logic               push;
  logic               pop;
  logic               is_last;
  logic signed [15:0] shifted;
  logic signed [15:0] x;
  logic [7:0]         y;
  logic               clip;
  logic               err;
  entry_t             head;
  entry_t             wr_entry;

  assign s_ready = (count != CW'(FIFO_DEPTH));
  assign m_valid = (count != '0);
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign is_last = (elem == EW'(VEC_LEN - 1));

  // An upstream overflow saturates toward the sign of the raw result.
  always_comb begin
    shifted = $signed(data_in) >>> SHIFT;
    x       = shifted;
    if (ovf_in) begin
      x = data_in[15] ? 16'sh8000 : 16'sh7fff;
    end
    y    = x[7:0];
    clip = 1'b0;
    if (RELU_EN != 0 && x < 16'sd0) begin
      y = 8'd0;
    end else if (x > 16'sd127) begin
      y    = 8'h7f;
      clip = 1'b1;
    end else if (x < -16'sd128) begin
      y    = 8'h80;
      clip = 1'b1;
    end
    err = ovf_in | clip;
  end

  always_comb begin
    wr_entry.data = y;
    wr_entry.last = is_last;
    wr_entry.vov  = is_last & (sticky | err);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem   <= '0;
      sticky <= 1'b0;
    end else if (push) begin
      if (is_last) begin
        elem   <= '0;
        sticky <= 1'b0;
      end else begin
        elem   <= elem + EW'(1);
        sticky <= sticky | err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        hold_data <= head.data;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Once drained, data_out keeps the last value handed downstream.
  assign head         = mem[rd_ptr];
  assign data_out     = m_valid ? head.data : hold_data;
  assign m_last       = m_valid & head.last;
  assign vec_overflow = m_valid & head.vov;

endmodule

// File: tb/tb_relu_requant_stage.sv
// Bench for relu_requant_stage: ReLU and passthrough instances share one stimulus
// stream; a scoreboard model predicts every output beat.
module tb_relu_requant_stage;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic [15:0] data_in;
  logic        ovf_in;
  logic        m_ready;

  logic        s_ready, s_ready2;
  logic        m_valid, m_valid2;
  logic [7:0]  data_out, data_out2;
  logic        m_last, m_last2;
  logic        vec_overflow, vec_overflow2;

  int nvec = 0;
  int nerr = 0;

  logic [9:0] q1[$];
  logic [9:0] q2[$];
  int         m_elem = 0;
  logic       st1 = 1'b0;
  logic       st2 = 1'b0;

  relu_requant_stage #(
    .VEC_LEN(3), .SHIFT(2), .RELU_EN(1), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .data_in(data_in), .ovf_in(ovf_in),
    .m_valid(m_valid), .m_ready(m_ready),
    .data_out(data_out), .m_last(m_last),
    .vec_overflow(vec_overflow)
  );

  relu_requant_stage #(
    .VEC_LEN(3), .SHIFT(2), .RELU_EN(0), .FIFO_DEPTH(4)
  ) u_dut_nr (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready2),
    .data_in(data_in), .ovf_in(ovf_in),
    .m_valid(m_valid2), .m_ready(m_ready),
    .data_out(data_out2), .m_last(m_last2),
    .vec_overflow(vec_overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [15:0] d,
                                       input logic o, input bit relu);
    int x;
    logic [7:0] y;
    logic e;
    x = int'($signed(d)) >>> 2;
    if (o) x = d[15] ? -32768 : 32767;
    e = o;
    if (relu && x < 0) y = 8'd0;
    else if (x > 127) begin y = 8'd127; e = 1'b1; end
    else if (x < -128) begin y = 8'h80; e = 1'b1; end
    else y = 8'(x);
    return {y, e};
  endfunction

  // Scoreboard: pop/compare on handshakes, predict and push on accepts.
  always @(negedge clk) begin
    if (reset) begin
      if (m_valid && m_ready) begin
        if (q1.size() == 0) chk("extra_beat", 1, 0);
        else chk("beat_relu", {data_out, m_last, vec_overflow}, q1.pop_front());
      end
      if (m_valid2 && m_ready) begin
        if (q2.size() == 0) chk("extra_beat_nr", 1, 0);
        else chk("beat_norelu", {data_out2, m_last2, vec_overflow2}, q2.pop_front());
      end
      if (s_valid && s_ready) begin
        logic [8:0] r1, r2;
        logic last;
        r1 = model(data_in, ovf_in, 1'b1);
        r2 = model(data_in, ovf_in, 1'b0);
        last = (m_elem == 2);
        q1.push_back({r1[8:1], last, last & (st1 | r1[0])});
        q2.push_back({r2[8:1], last, last & (st2 | r2[0])});
        if (last) begin
          m_elem = 0; st1 = 1'b0; st2 = 1'b0;
        end else begin
          m_elem++; st1 = st1 | r1[0]; st2 = st2 | r2[0];
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic o);
    s_valid = 1'b1; data_in = d; ovf_in = o;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        s_valid = 1'b0; ovf_in = 1'b0;
        return;
      end
    end
    nvec++; nerr++;
    $error("FAIL send_timeout: observed no accept expected accept");
    s_valid = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 60 && (q1.size() != 0 || q2.size() != 0); i++)
      @(posedge clk);
    #1;
    chk("drain_left", q1.size() + q2.size(), 0);
    chk("drain_empty", m_valid, 0);
  endtask

  initial begin
    logic [7:0] held;
    reset = 1'b0; s_valid = 1'b0; data_in = '0; ovf_in = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_vov", vec_overflow, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_s_ready", s_ready, 1);

    // pass-through, one-cycle latency
    m_ready = 1'b1;
    send(16'd400, 1'b0);
    chk("lat_valid", m_valid, 1);
    chk("lat_data", data_out, 8'd100);
    send(-16'sd20, 1'b0);
    send(16'd100, 1'b0);
    chk("last_flag", m_last, 1);
    drain();
    chk("hold_data", data_out, 8'd25);

    // saturation and sticky clear
    send(16'd1000, 1'b0); send(16'd4, 1'b0); send(16'd8, 1'b0);
    send(16'd4, 1'b0); send(16'd4, 1'b0); send(16'd4, 1'b0);
    drain();

    // overflow flag on both ReLU settings
    send(-16'sd5, 1'b1);
    chk("ovf_relu", data_out, 8'd0);
    chk("ovf_norelu", data_out2, 8'h80);
    send(-16'sd20, 1'b0);
    chk("nr_neg", data_out2, 8'hfb);
    send(16'd8, 1'b0);
    drain();

    // backpressure
    m_ready = 1'b0;
    send(16'd40, 1'b0); send(16'd80, 1'b0);
    send(-16'sd8, 1'b0); send(16'd12, 1'b0);
    chk("full_s_ready", s_ready, 0);
    s_valid = 1'b1; data_in = 16'd16;
    held = data_out;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_stable", data_out, held);
    chk("stall_head", data_out, 8'd10);
    chk("stall_s_ready", s_ready, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("pulse_s_ready", s_ready, 1);
    chk("pulse_head", data_out, 8'd20);
    send(16'd16, 1'b0);
    drain();

    // reset mid-vector
    m_ready = 1'b0;
    send(16'd20, 1'b0); send(16'd24, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 0);
    q1.delete(); q2.delete();
    m_elem = 0; st1 = 1'b0; st2 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_ready = 1'b1;
    send(16'd28, 1'b0); send(16'd32, 1'b0); send(16'd36, 1'b0);
    chk("midrst_last", m_last, 1);
    drain();

    // concurrent push/pop at count 2
    m_ready = 1'b0;
    send(16'd44, 1'b0); send(-16'sd48, 1'b0);
    m_ready = 1'b1; s_valid = 1'b1; data_in = 16'd52;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cc_m_valid", m_valid, 1);
      chk("cc_s_ready", s_ready, 1);
      @(posedge clk); #1;
      data_in = 16'(56 + 4 * i);
    end
    s_valid = 1'b0;
    drain();

    chk("end_q1", q1.size(), 0);
    chk("end_q2", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
